seg7_scan_driver: RTL

//  Consumer end of the timer display interface: takes the HH:MM BCD digits from the timer and

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/bcd_to_seg7.sv | 25 ++
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and register layouts for the multiplexed 7-segment scan driver.
package seg7_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic ADDR_CTRL = 1'b0;
  localparam logic ADDR_DP   = 1'b1;

  typedef struct packed {
    logic       lzs;
    logic       blank;
    logic [3:0] bright;
  } ctrl_t;

  typedef struct packed {
    logic       blink_en;
    logic [3:0] dp_mask;
  } dp_cfg_t;

  localparam ctrl_t   CTRL_RESET = 6'b10_1111;
  localparam dp_cfg_t DP_RESET   = 5'b1_0100;

  function automatic int digit_cycles(input int clk_hz, input int refresh_hz);
    return clk_hz / (4 * refresh_hz);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder; anything above 9 shows a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans the HH:MM snapshot across a 4-digit common-anode display with guard time,
// brightness PWM, blanking, leading-zero suppression and a blinking colon.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hour1,
  input  logic [3:0] hour0,
  input  logic [2:0] min1,
  input  logic [3:0] min0,
  input  logic       sel,
  input  logic       address,
  input  logic [5:0] data_in,
  input  logic       write_en,
  output logic [5:0] data_out,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIGIT_CYCLES = digit_cycles(CLK_HZ, REFRESH_HZ);
  localparam int SLOT_W       = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int HALF_FRAMES  = (REFRESH_HZ / 2 > 0) ? REFRESH_HZ / 2 : 1;
  localparam int FRAME_W      = (HALF_FRAMES > 1) ? $clog2(HALF_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]  GUARD      = SLOT_W'(GUARD_CYCLES);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(HALF_FRAMES - 1);

  ctrl_t              ctrl;
  dp_cfg_t            dp_cfg;
  logic [SLOT_W-1:0]  slot;
  logic [1:0]         idx;
  logic [3:0]         pwm;
  logic [FRAME_W-1:0] frame_cnt;
  logic               phase;
  logic [1:0]         snap_hour1;
  logic [3:0]         snap_hour0;
  logic [2:0]         snap_min1;
  logic [3:0]         snap_min0;
  logic               slot_wrap;
  logic               frame_wrap;
  logic [3:0]         digit;
  logic [6:0]         seg_code;
  logic               active;

  assign slot_wrap  = (slot == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl   <= CTRL_RESET;
      dp_cfg <= DP_RESET;
    end else if (sel && write_en) begin
      if (address == ADDR_CTRL) ctrl <= ctrl_t'(data_in);
      else                      dp_cfg <= dp_cfg_t'(data_in[4:0]);
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) data_out = (address == ADDR_CTRL) ? ctrl : {1'b0, dp_cfg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      idx  <= '0;
      pwm  <= '0;
    end else begin
      pwm  <= pwm + 4'd1;
      slot <= slot_wrap ? '0 : slot + 1'b1;
      if (slot_wrap) idx <= idx + 2'd1;
    end
  end

  // Blink phase flips once per half second of frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Digits are latched only at frame boundaries so a frame never mixes two times.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_hour1 <= '0;
      snap_hour0 <= '0;
      snap_min1  <= '0;
      snap_min0  <= '0;
    end else if (frame_wrap) begin
      snap_hour1 <= hour1;
      snap_hour0 <= hour0;
      snap_min1  <= min1;
      snap_min0  <= min0;
    end
  end

  always_comb begin
    case (idx)
      2'd0:    digit = snap_min0;
      2'd1:    digit = {1'b0, snap_min1};
      2'd2:    digit = snap_hour0;
      default: digit = {2'b00, snap_hour1};
    endcase
  end

  bcd_to_seg7 u_decoder (
    .value (digit),
    .seg   (seg_code)
  );

  assign active = !ctrl.blank && (slot >= GUARD) && (pwm <= ctrl.bright) &&
                  !((idx == 2'd3) && ctrl.lzs && (snap_hour1 == 2'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'hF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= active ? ~(4'b0001 << idx) : 4'hF;
      seg <= seg_code;
      dp  <= ~(dp_cfg.dp_mask[idx] && (!dp_cfg.blink_en || phase) && active);
    end
  end

endmodule
